// File: rtl/mandelbrot_multi_solver_pkg.sv
// rtl/mandelbrot_multi_solver_pkg.sv - shared fixed-point constants, widths and solver state encoding
package mandelbrot_multi_solver_pkg;

   localparam int FIX_W  = 27;
   localparam int FRAC_W = 20;
   localparam int PROD_W = 2 * FIX_W;
   localparam int MAG_W  = PROD_W + 2;
   localparam int RES_W  = 8;
   localparam int KW     = 20;

   // 4.0 expressed in the Q14.40 scale of the raw squared products
   localparam logic signed [MAG_W-1:0] ESCAPE_LIMIT = MAG_W'(64'sd4 <<< (2 * FRAC_W));

   typedef logic signed [FIX_W-1:0] fix_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEEK  = 3'd1,
      ST_INIT  = 3'd2,
      ST_ITER  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } solver_state_t;

endpackage

// File: rtl/mandelbrot_solver_core.sv
// rtl/mandelbrot_solver_core.sv - one escape-time core: coordinate walker, iteration datapath, FSM, result RAM
// Optional MULTI_SOLVER_CARDIOID_EN short-circuits main-cardioid / period-2-bulb points in INIT.
module mandelbrot_solver_core
   import mandelbrot_multi_solver_pkg::*;
#(
   parameter int SOLVER_ID    = 0,
   parameter int NUM_SOLVERS  = 10,
   parameter int MAX_ITER     = 255,
   parameter int RESULT_DEPTH = 4096,
   parameter int AW           = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  fix_t             min_x,
   input  fix_t             min_y,
   input  fix_t             max_x,
   input  fix_t             max_y,
   input  fix_t             dx,
   input  fix_t             dy,
   input  logic [AW-1:0]    rd_addr,
   output logic [RES_W-1:0] rd_word,
   output logic             solver_done
);

   solver_state_t state;
   fix_t cfg_min_x, cfg_min_y, cfg_max_x, cfg_max_y, cfg_dx, cfg_dy;
   fix_t px, py, zr, zi;
   logic [6:0] rem;
   logic [RES_W-1:0] n, result;
   logic [KW-1:0] k;
   logic [RES_W-1:0] ram [RESULT_DEPTH];

   fix_t x_adv, y_adv, step_x, step_y, zr_next, zi_next;
   logic wrap_row, step_end, escape;
   logic signed [PROD_W-1:0] rr, ii, ri;
   logic signed [MAG_W-1:0] mag;

   always_comb begin
      x_adv    = px + cfg_dx;
      y_adv    = py + cfg_dy;
      wrap_row = x_adv >= cfg_max_x;
      step_x   = wrap_row ? cfg_min_x : x_adv;
      step_y   = wrap_row ? y_adv : py;
      step_end = wrap_row && (y_adv >= cfg_max_y);
      rr       = zr * zr;
      ii       = zi * zi;
      ri       = zr * zi;
      mag      = MAG_W'(rr) + MAG_W'(ii);
      escape   = mag > ESCAPE_LIMIT;
      // truncating each shifted product then summing equals truncating the sum mod 2^27
      zr_next  = fix_t'(rr >>> FRAC_W) - fix_t'(ii >>> FRAC_W) + px;
      zi_next  = (fix_t'(ri >>> FRAC_W) <<< 1) + py;
   end

`ifdef MULTI_SOLVER_CARDIOID_EN
   logic signed [63:0] xq, y_sq, q20, card_lhs, bulb_x, bulb_sq;
   logic in_range, in_set;

   // a small margin keeps boundary points iterating so results never depend on the shortcut
   always_comb begin
      xq       = 64'(px) - 64'sd262144;
      y_sq     = 64'(py) * 64'(py);
      q20      = (xq * xq + y_sq) >>> FRAC_W;
      card_lhs = q20 * (q20 + xq);
      bulb_x   = 64'(px) + 64'sd1048576;
      bulb_sq  = bulb_x * bulb_x + y_sq;
      in_range = (64'(px) >= -64'sd2097152) && (64'(px) <= 64'sd1048576) &&
                 (64'(py) >= -64'sd2097152) && (64'(py) <= 64'sd2097152);
      in_set   = in_range && (((card_lhs + 64'sd16777216) < (y_sq >>> 2)) ||
                              ((bulb_sq + 64'sd16777216) < 64'sd68719476736));
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cfg_min_x <= '0;
         cfg_min_y <= '0;
         cfg_max_x <= '0;
         cfg_max_y <= '0;
         cfg_dx    <= '0;
         cfg_dy    <= '0;
         px        <= '0;
         py        <= '0;
         zr        <= '0;
         zi        <= '0;
         rem       <= '0;
         n         <= '0;
         result    <= '0;
         k         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cfg_min_x <= min_x;
               cfg_min_y <= min_y;
               cfg_max_x <= max_x;
               cfg_max_y <= max_y;
               cfg_dx    <= dx;
               cfg_dy    <= dy;
               px        <= min_x;
               py        <= min_y;
               rem       <= 7'(SOLVER_ID);
               k         <= '0;
               state     <= ST_SEEK;
            end
            ST_SEEK: begin
               if (rem == 7'd0) begin
                  state <= ST_INIT;
               end else begin
                  px  <= step_x;
                  py  <= step_y;
                  rem <= rem - 7'd1;
                  if (step_end)
                     state <= ST_DONE;
                  else if (rem == 7'd1)
                     state <= ST_INIT;
               end
            end
            ST_INIT: begin
               zr <= '0;
               zi <= '0;
               n  <= '0;
`ifdef MULTI_SOLVER_CARDIOID_EN
               if (in_set) begin
                  result <= RES_W'(MAX_ITER);
                  state  <= ST_WRITE;
               end else begin
                  state <= ST_ITER;
               end
`else
               state <= ST_ITER;
`endif
            end
            ST_ITER: begin
               if (escape) begin
                  result <= n;
                  state  <= ST_WRITE;
               end else if (n == RES_W'(MAX_ITER - 1)) begin
                  result <= RES_W'(MAX_ITER);
                  state  <= ST_WRITE;
               end else begin
                  zr <= zr_next;
                  zi <= zi_next;
                  n  <= n + RES_W'(1);
               end
            end
            ST_WRITE: begin
               if (k != KW'(RESULT_DEPTH))
                  k <= k + KW'(1);
               rem   <= 7'(NUM_SOLVERS);
               state <= ST_SEEK;
            end
            default: state <= ST_DONE;
         endcase
      end
   end

   // result RAM is never reset so a restarted run leaves earlier words intact
   always_ff @(posedge clock) begin
      if (state == ST_WRITE && k < KW'(RESULT_DEPTH))
         ram[k[AW-1:0]] <= result;
      rd_word <= ram[rd_addr];
   end

   assign solver_done = (state == ST_DONE);

endmodule

// File: rtl/mandelbrot_multi_solver.sv
// rtl/mandelbrot_multi_solver.sv - NUM_SOLVERS interleaved escape-time cores with a shared result read port
// Optional MULTI_SOLVER_CARDIOID_EN is forwarded to every core.
module mandelbrot_multi_solver
   import mandelbrot_multi_solver_pkg::*;
#(
   parameter int NUM_SOLVERS  = 10,
   parameter int MAX_ITER     = 255,
   parameter int RESULT_DEPTH = 4096
) (
   input  logic             clock,
   input  logic             reset,
   input  fix_t             min_x,
   input  fix_t             min_y,
   input  fix_t             max_x,
   input  fix_t             max_y,
   input  fix_t             dx,
   input  fix_t             dy,
   input  logic [5:0]       rd_solver_id,
   input  logic [18:0]      rd_addr,
   output logic [RES_W-1:0] rd_data,
   output logic             done
);

   localparam int AW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;

   logic [RES_W-1:0] core_word [NUM_SOLVERS];
   logic [NUM_SOLVERS-1:0] core_done;
   logic [5:0] sel_id;
   logic sel_ok;

   for (genvar s = 0; s < NUM_SOLVERS; s++) begin : g_core
      mandelbrot_solver_core #(
         .SOLVER_ID    (s),
         .NUM_SOLVERS  (NUM_SOLVERS),
         .MAX_ITER     (MAX_ITER),
         .RESULT_DEPTH (RESULT_DEPTH),
         .AW           (AW)
      ) u_core (
         .clock       (clock),
         .reset       (reset),
         .min_x       (min_x),
         .min_y       (min_y),
         .max_x       (max_x),
         .max_y       (max_y),
         .dx          (dx),
         .dy          (dy),
         .rd_addr     (rd_addr[AW-1:0]),
         .rd_word     (core_word[s]),
         .solver_done (core_done[s])
      );
   end

   // the RAM read is registered inside each core; the select is registered alongside it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel_id <= '0;
         sel_ok <= 1'b0;
         done   <= 1'b0;
      end else begin
         sel_id <= rd_solver_id;
         sel_ok <= ({1'b0, rd_solver_id} < 7'(NUM_SOLVERS)) &&
                   ({1'b0, rd_addr} < 20'(RESULT_DEPTH));
         done   <= &core_done;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int s = 0; s < NUM_SOLVERS; s++)
         if (sel_ok && sel_id == 6'(s))
            rd_data = core_word[s];
   end

endmodule

// File: tb/tb_mandelbrot_multi_solver.sv
// tb/tb_mandelbrot_multi_solver.sv - randomized region runs checked against a plain-arithmetic escape-time model
module tb_mandelbrot_multi_solver;

   localparam int NS    = 10;
   localparam int MI    = 255;
   localparam int DEPTH = 12;

   logic               clock = 1'b0;
   logic               reset;
   logic signed [26:0] min_x, min_y, max_x, max_y, dx, dy;
   logic [5:0]         rd_solver_id;
   logic [18:0]        rd_addr;
   logic [7:0]         rd_data;
   logic               done;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ram [NS][DEPTH];

   mandelbrot_multi_solver #(
      .NUM_SOLVERS  (NS),
      .MAX_ITER     (MI),
      .RESULT_DEPTH (DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .min_x        (min_x),
      .min_y        (min_y),
      .max_x        (max_x),
      .max_y        (max_y),
      .dx           (dx),
      .dy           (dy),
      .rd_solver_id (rd_solver_id),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .done         (done)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint wrap27(input longint v);
      longint t;
      t = v & 134217727;
      if (t >= 67108864)
         t = t - 134217728;
      return t;
   endfunction

   function automatic int escape_count(input longint cx, input longint cy);
      longint zr = 0;
      longint zi = 0;
      longint rr, ii, ri;
      for (int n = 0; n < MI; n++) begin
         rr = zr * zr;
         ii = zi * zi;
         if (rr + ii > (longint'(4) <<< 40))
            return n;
         ri = zr * zi;
         zr = wrap27((rr >>> 20) - (ii >>> 20) + cx);
         zi = wrap27(2 * (ri >>> 20) + cy);
      end
      return MI;
   endfunction

   task automatic model_region(input longint mnx, input longint mny, input longint mxx,
                               input longint mxy, input longint ddx, input longint ddy,
                               output int npix);
      longint x = mnx;
      longint y = mny;
      int p = 0;
      while (p < 4096) begin
         if (p / NS < DEPTH)
            exp_ram[p % NS][p / NS] = escape_count(x, y);
         p++;
         x = x + ddx;
         if (x >= mxx) begin
            x = mnx;
            y = y + ddy;
            if (y >= mxy)
               break;
         end
      end
      npix = p;
   endtask

   task automatic start_run(input longint mnx, input longint mny, input longint mxx,
                            input longint mxy, input longint ddx, input longint ddy);
      @(negedge clock);
      reset = 1'b0;
      min_x = 27'(mnx);
      min_y = 27'(mny);
      max_x = 27'(mxx);
      max_y = 27'(mxy);
      dx    = 27'(ddx);
      dy    = 27'(ddy);
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic wait_done(input int npix);
      int budget = ((npix + NS - 1) / NS) * (NS + MI + 6) + 4 * NS + 40;
      int cyc = 0;
      while (!done && cyc < budget) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      check_val("done_rise", int'(done), 1);
   endtask

   task automatic read_word(input int id, input int addr, output int d);
      @(negedge clock);
      rd_solver_id = 6'(id);
      rd_addr      = 19'(addr);
      @(posedge clock);
      #1;
      d = int'(rd_data);
   endtask

   task automatic check_ram(input string tag);
      int d;
      for (int s = 0; s < NS; s++)
         for (int a = 0; a < DEPTH; a++) begin
            read_word(s, a, d);
            check_val($sformatf("%s_s%0d_a%0d", tag, s, a), d, exp_ram[s][a]);
         end
      read_word(12, 0, d);
      check_val({tag, "_id12"}, d, 0);
      read_word(NS, 1, d);
      check_val({tag, "_idN"}, d, 0);
      read_word(0, DEPTH, d);
      check_val({tag, "_addr_depth"}, d, 0);
      read_word(3, 262144, d);
      check_val({tag, "_addr_high"}, d, 0);
      check_val({tag, "_done_held"}, int'(done), 1);
   endtask

   task automatic run_region(input string tag, input longint mnx, input longint mny,
                             input longint mxx, input longint mxy, input longint ddx,
                             input longint ddy);
      int npix;
      model_region(mnx, mny, mxx, mxy, ddx, ddy, npix);
      start_run(mnx, mny, mxx, mxy, ddx, ddy);
      wait_done(npix);
      check_ram(tag);
   endtask

   initial begin
      int d, cols, rows, ddx, ddy, mnx, mny, npix;
      reset        = 1'b0;
      min_x        = '0;
      min_y        = '0;
      max_x        = '0;
      max_y        = '0;
      dx           = '0;
      dy           = '0;
      rd_solver_id = '0;
      rd_addr      = '0;
      for (int s = 0; s < NS; s++)
         for (int a = 0; a < DEPTH; a++)
            exp_ram[s][a] = 0;

      repeat (3) @(posedge clock);
      #1;
      check_val("reset_rd_data", int'(rd_data), 0);
      check_val("reset_done", int'(done), 0);

      run_region("origin", 0, 0, 1, 1, 1, 1);
      read_word(0, 0, d);
      check_val("origin_const", d, 255);

      run_region("one_one", 1 << 20, 1 << 20, (1 << 20) + 1, (1 << 20) + 1, 1, 1);
      read_word(0, 0, d);
      check_val("one_one_const", d, 2);

      run_region("minus_two", -(2 << 20), 0, -(2 << 20) + 1, 1, 1, 1);
      read_word(0, 0, d);
      check_val("minus_two_const", d, 255);

      run_region("corner", -(2 << 20), -(1 << 20), -(2 << 20) + 1, -(1 << 20) + 1, 1, 1);

      run_region("row25", -(2 << 20), 0, -(2 << 20) + 25 * (1 << 17), 1, 1 << 17, 1);
      read_word(5, 2, d);
      check_val("row25_s5_a2_unwritten", d, 0);

      for (int r = 0; r < 4; r++) begin
         cols = $urandom_range(5, 24);
         rows = $urandom_range(2, 8);
         ddx  = $urandom_range(1 << 16, 1 << 18);
         ddy  = $urandom_range(1 << 16, 1 << 18);
         mnx  = int'($urandom_range(0, 2097152)) - 2621440;
         mny  = int'($urandom_range(0, 1572864)) - 1310720;
         run_region($sformatf("rand%0d", r), mnx, mny,
                    mnx + (cols - 1) * ddx + 1 + int'($urandom_range(0, ddx - 1)),
                    mny + (rows - 1) * ddy + 1 + int'($urandom_range(0, ddy - 1)),
                    ddx, ddy);
      end

      ddx = 1 << 17;
      ddy = 3 << 16;
      mnx = -(2 << 20);
      mny = -(1 << 20);
      model_region(mnx, mny, mnx + 20 * ddx, mny + 7 * ddy, ddx, ddy, npix);
      start_run(mnx, mny, mnx + 20 * ddx, mny + 7 * ddy, ddx, ddy);
      repeat ($urandom_range(100, 1500)) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_val("midrun_reset_done", int'(done), 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      wait_done(npix);
      check_ram("midrun");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
